// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and small helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned DEF_WIDTH        = 32;
    localparam int unsigned DEF_ILEN         = 32;
    localparam int unsigned DEF_STEP         = 4;
    localparam int unsigned DEF_RESET_VECTOR = 0;
    localparam int unsigned STATE_W          = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_e;

    // A redirect target is misaligned when it is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response channel plus the decode-side output channel.
interface pc_fetch_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ILEN  = 32
);

    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [ILEN-1:0]  imem_rsp_data;
    logic             if_valid;
    logic             if_ready;
    logic [WIDTH-1:0] if_pc;
    logic [ILEN-1:0]  if_instr;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output if_valid,
        output if_pc,
        output if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output if_ready
    );

endinterface

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready holding register for a fetched {pc, instr} pair.
module fetch_out_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ILEN  = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [ILEN-1:0]  i_instr,
    input  logic             i_flush,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_pc,
    output logic [ILEN-1:0]  o_instr
);

    logic             r_valid;
    logic [WIDTH-1:0] r_pc;
    logic [ILEN-1:0]  r_instr;

    // Flush wins over load; a load on the consuming edge keeps the entry full.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_load && !i_flush) begin
                r_pc    <= i_pc;
                r_instr <= i_instr;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction-fetch sequencer with redirect/kill handling.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH        = DEF_WIDTH,
    parameter int unsigned      ILEN         = DEF_ILEN,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter int unsigned      STEP         = DEF_STEP
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             misaligned_err,
    pc_fetch_unit_if.master  bus
);

    localparam logic [STATE_W-1:0] ST_IDLE  = IDLE;
    localparam logic [STATE_W-1:0] ST_FETCH = FETCH;
    localparam logic [STATE_W-1:0] ST_WAIT  = WAIT;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   w_pc_nxt;
    logic [WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]   w_addr_nxt;
    logic [WIDTH-1:0]   r_fetch_pc;
    logic [WIDTH-1:0]   w_fetch_pc_nxt;
    logic               r_kill;
    logic               w_kill_nxt;
    logic               r_stale;
    logic               w_stale_nxt;
    logic               r_mis;

    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_req_hold;
    logic               w_load;
    logic [WIDTH-1:0]   w_target;
    logic               w_if_valid;
    logic [WIDTH-1:0]   w_if_pc;
    logic [ILEN-1:0]    w_if_instr;

    assign w_target = {redirect_target[WIDTH-1:2], 2'b00};

    // Requests depend on the same-cycle decode handshake so a slot freed this cycle can be refilled;
    // once raised the request stays up because nothing but a response can refill the slot in FETCH.
    assign w_req_valid = (r_state == ST_FETCH) && (!w_if_valid || bus.if_ready);
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_req_hold  = w_req_valid && !bus.imem_req_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_VECTOR;
            r_addr     <= RESET_VECTOR;
            r_fetch_pc <= RESET_VECTOR;
            r_kill     <= 1'b0;
            r_stale    <= 1'b0;
            r_mis      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_kill     <= w_kill_nxt;
            r_stale    <= w_stale_nxt;
            r_mis      <= redirect_valid && is_misaligned(redirect_target[1:0]);
        end
    end

    // r_stale marks a held request whose address predates a redirect; its response must be killed.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_addr_nxt     = r_addr;
        w_fetch_pc_nxt = r_fetch_pc;
        w_kill_nxt     = r_kill;
        w_stale_nxt    = r_stale;
        w_load         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_req_fire) begin
                    w_state_nxt    = ST_WAIT;
                    w_fetch_pc_nxt = r_addr;
                    w_kill_nxt     = r_stale;
                    w_stale_nxt    = 1'b0;
                    if (!r_stale) begin
                        w_pc_nxt = r_pc + WIDTH'(STEP);
                    end
                    w_addr_nxt = w_pc_nxt;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    w_state_nxt = ST_FETCH;
                    w_load      = !r_kill;
                    w_kill_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (redirect_valid) begin
            w_pc_nxt = w_target;
            w_load   = 1'b0;
            if (w_req_hold) begin
                w_stale_nxt = 1'b1;
            end else begin
                w_addr_nxt = w_target;
            end
            if (w_req_fire || ((r_state == ST_WAIT) && !bus.imem_rsp_valid)) begin
                w_kill_nxt = 1'b1;
            end
        end
    end

    fetch_out_reg #(
        .WIDTH (WIDTH),
        .ILEN  (ILEN)
    ) u_out_reg (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_load  (w_load),
        .i_pc    (r_fetch_pc),
        .i_instr (bus.imem_rsp_data),
        .i_flush (redirect_valid),
        .i_ready (bus.if_ready),
        .o_valid (w_if_valid),
        .o_pc    (w_if_pc),
        .o_instr (w_if_instr)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_addr;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_pc          = w_if_pc;
    assign bus.if_instr       = w_if_instr;
    assign misaligned_err     = r_mis;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench: directed steps plus randomized traffic checked against a transaction-level model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV_A = 32'h0000_0100;
    localparam logic [7:0]  RV_B = 8'hF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        n_rst_b;
    logic        redirect_valid;
    logic        redirect_valid_b;
    logic [31:0] redirect_target;
    logic [7:0]  redirect_target_b;
    logic        misaligned_err;
    logic        misaligned_err_b;

    pc_fetch_unit_if #(.WIDTH(32), .ILEN(32)) a_if ();
    pc_fetch_unit_if #(.WIDTH(8),  .ILEN(32)) b_if ();

    pc_fetch_unit #(.WIDTH(32), .ILEN(32), .RESET_VECTOR(RV_A), .STEP(4)) u_dut_a (
        .clk             (clk),
        .n_rst           (n_rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misaligned_err  (misaligned_err),
        .bus             (a_if)
    );

    pc_fetch_unit #(.WIDTH(8), .ILEN(32), .RESET_VECTOR(RV_B), .STEP(4)) u_dut_b (
        .clk             (clk),
        .n_rst           (n_rst_b),
        .redirect_valid  (redirect_valid_b),
        .redirect_target (redirect_target_b),
        .misaligned_err  (misaligned_err_b),
        .bus             (b_if)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cons  = 0;
    int          rem     = 0;
    int          lat     = 1;
    bit          outst   = 1'b0;
    bit          prev_stall = 1'b0;
    bit          stray   = 1'b0;
    logic [31:0] out_addr  = '0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_pc    = RV_A;

    logic        obs_valid;
    logic [31:0] obs_addr;
    logic        obs_ifv;
    logic [31:0] obs_ifpc;
    logic [31:0] obs_instr;
    logic        obs_b_valid;
    logic [7:0]  obs_b_addr;
    logic        obs_b_ifv;
    logic [7:0]  obs_b_ifpc;
    logic [31:0] obs_b_instr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // One clock of DUT A: drive inputs, play the memory, check the delivered stream and protocol.
    task automatic cyc(input bit rdy, input bit ifr, input bit redir, input logic [31:0] tgt);
        logic fire;
        logic rsp_now;
        @(negedge clk);
        a_if.imem_req_ready = rdy;
        a_if.if_ready       = ifr;
        redirect_valid      = redir;
        redirect_target     = tgt;
        a_if.imem_rsp_valid = stray;
        a_if.imem_rsp_data  = $urandom;
        if (outst) begin
            rem--;
            if (rem == 0) begin
                a_if.imem_rsp_valid = 1'b1;
                a_if.imem_rsp_data  = memf(out_addr);
            end
        end
        #1;
        obs_valid = a_if.imem_req_valid;
        obs_addr  = a_if.imem_req_addr;
        obs_ifv   = a_if.if_valid;
        obs_ifpc  = a_if.if_pc;
        obs_instr = a_if.if_instr;
        if (prev_stall) begin
            chk("req_hold_valid", 32'(obs_valid), 32'd1);
            chk("req_hold_addr", obs_addr, prev_addr);
        end
        chk("single_outstanding", 32'(obs_valid && outst), 32'd0);
        if (obs_ifv && ifr) begin
            chk("if_pc", obs_ifpc, exp_pc);
            chk("if_instr", obs_instr, memf(exp_pc));
            exp_pc += 32'd4;
            n_cons++;
        end
        if (redir) exp_pc = {tgt[31:2], 2'b00};
        fire       = obs_valid && rdy;
        prev_stall = obs_valid && !rdy;
        prev_addr  = obs_addr;
        rsp_now    = a_if.imem_rsp_valid && outst;
        @(posedge clk);
        if (rsp_now) outst = 1'b0;
        if (fire) begin
            outst    = 1'b1;
            rem      = lat;
            out_addr = obs_addr;
        end
        #1;
        chk("misaligned_err", 32'(misaligned_err), 32'(redir && (tgt[1:0] != 2'b00)));
    endtask

    task automatic cyc_b(input bit rsp, input logic [7:0] rsp_addr);
        @(negedge clk);
        b_if.imem_rsp_valid = rsp;
        b_if.imem_rsp_data  = memf({24'h0, rsp_addr});
        #1;
        obs_b_valid = b_if.imem_req_valid;
        obs_b_addr  = b_if.imem_req_addr;
        obs_b_ifv   = b_if.if_valid;
        obs_b_ifpc  = b_if.if_pc;
        obs_b_instr = b_if.if_instr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        int cons_mark;
        n_rst = 1'b1;
        n_rst_b = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = '0;
        redirect_valid_b = 1'b0;
        redirect_target_b = '0;
        a_if.imem_req_ready = 1'b0;
        a_if.imem_rsp_valid = 1'b0;
        a_if.imem_rsp_data = '0;
        a_if.if_ready = 1'b0;
        b_if.imem_req_ready = 1'b1;
        b_if.imem_rsp_valid = 1'b0;
        b_if.imem_rsp_data = '0;
        b_if.if_ready = 1'b1;
        #2;
        n_rst = 1'b0;
        n_rst_b = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(a_if.imem_req_valid), 32'd0);
        chk("rst_req_addr", a_if.imem_req_addr, RV_A);
        chk("rst_if_valid", 32'(a_if.if_valid), 32'd0);
        chk("rst_if_pc", a_if.if_pc, 32'd0);
        chk("rst_if_instr", a_if.if_instr, 32'd0);
        chk("rst_misaligned", 32'(misaligned_err), 32'd0);
        n_rst = 1'b1;

        // Sequential stream from 0x100, one instruction every other cycle.
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            if (i == 0) chk("first_req_idle", 32'(obs_valid), 32'd0);
            if (i == 1) begin
                chk("first_req_valid", 32'(obs_valid), 32'd1);
                chk("first_req_addr", obs_addr, RV_A);
            end
            chk("ifv_pattern", 32'(obs_ifv), 32'((i >= 3) && (i % 2 == 1)));
            if ((i >= 3) && (i % 2 == 1)) chk("if_pc_seq", obs_ifpc, RV_A + 32'(4 * ((i - 3) / 2)));
        end

        // Decode back-pressure holds the entry and blocks new requests.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            chk("bp_if_valid", 32'(obs_ifv), 32'd1);
            chk("bp_if_pc", obs_ifpc, 32'h10C);
            chk("bp_if_instr", obs_instr, memf(32'h10C));
            chk("bp_no_req", 32'(obs_valid), 32'd0);
        end
        lat = 3;
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("bp_resume_valid", 32'(obs_valid), 32'd1);
        chk("bp_resume_addr", obs_addr, 32'h110);

        // Redirect during WAIT kills the late response.
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("kill_wait_noreq", 32'(obs_valid), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("kill_rsp_noreq", 32'(obs_valid), 32'd0);
        lat = 1;
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("kill_no_ifv", 32'(obs_ifv), 32'd0);
        chk("kill_next_valid", 32'(obs_valid), 32'd1);
        chk("kill_next_addr", obs_addr, 32'h200);

        // Misaligned redirect coinciding with a response.
        cyc(1'b1, 1'b1, 1'b1, 32'h2);
        chk("mis_pulse", 32'(misaligned_err), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_cleared", 32'(misaligned_err), 32'd0);
        chk("mis_next_addr", obs_addr, 32'h0);
        chk("mis_rsp_dropped", 32'(obs_ifv), 32'd0);

        // Memory stall with a redirect in the middle of it.
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, (i == 1), 32'h300);
            chk("stall_valid", 32'(obs_valid), 32'd1);
            chk("stall_addr", obs_addr, 32'h4);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_accept_addr", obs_addr, 32'h4);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_rsp_noreq", 32'(obs_valid), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_killed_ifv", 32'(obs_ifv), 32'd0);
        chk("stall_next_addr", obs_addr, 32'h300);

        // Randomized traffic.
        cons_mark = n_cons;
        for (int i = 0; i < 400; i++) begin
            lat = int'($urandom_range(3, 1));
            cyc($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7,
                $urandom_range(19, 0) == 0, $urandom);
        end
        lat = 1;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("random_progress", 32'(n_cons - cons_mark > 20), 32'd1);

        // Reset asserted while a fetch is outstanding, then stray responses.
        lat = 3;
        guard = 0;
        while (!outst && guard < 20) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            guard++;
        end
        chk("reach_wait", 32'(outst), 32'd1);
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst_addr", a_if.imem_req_addr, RV_A);
        chk("midrst_valid", 32'(a_if.imem_req_valid), 32'd0);
        chk("midrst_if_valid", 32'(a_if.if_valid), 32'd0);
        outst = 1'b0;
        prev_stall = 1'b0;
        exp_pc = RV_A;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        stray = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("stray_idle_noreq", 32'(obs_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("stray_fetch_addr", obs_addr, RV_A);
        stray = 1'b0;
        lat = 1;
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stray_not_loaded", 32'(obs_ifv), 32'd0);
        cons_mark = n_cons;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_rst_progress", 32'(n_cons - cons_mark), 32'd2);

        // 8-bit instance: address wrap, then reset while waiting.
        @(posedge clk);
        #1;
        n_rst_b = 1'b1;
        cyc_b(1'b0, 8'h0);
        chk("b_idle_noreq", 32'(obs_b_valid), 32'd0);
        cyc_b(1'b0, 8'h0);
        chk("b_addr0", 32'(obs_b_addr), 32'h00F8);
        chk("b_valid0", 32'(obs_b_valid), 32'd1);
        cyc_b(1'b1, 8'hF8);
        cyc_b(1'b0, 8'h0);
        chk("b_addr1", 32'(obs_b_addr), 32'h00FC);
        chk("b_ifpc0", 32'(obs_b_ifpc), 32'h00F8);
        chk("b_instr0", obs_b_instr, memf(32'h00F8));
        cyc_b(1'b1, 8'hFC);
        cyc_b(1'b0, 8'h0);
        chk("b_wrap_addr", 32'(obs_b_addr), 32'h0000);
        chk("b_ifpc1", 32'(obs_b_ifpc), 32'h00FC);
        chk("b_ifv1", 32'(obs_b_ifv), 32'd1);
        @(negedge clk);
        #2;
        n_rst_b = 1'b0;
        #1;
        chk("b_rst_addr", 32'(b_if.imem_req_addr), 32'(RV_B));
        chk("b_rst_valid", 32'(b_if.imem_req_valid), 32'd0);
        chk("b_rst_if_valid", 32'(b_if.if_valid), 32'd0);
        chk("b_rst_if_pc", 32'(b_if.if_pc), 32'd0);
        chk("b_rst_if_instr", b_if.if_instr, 32'd0);
        chk("b_misaligned", 32'(misaligned_err_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
